dp_exec_ctrl: RTL and testbench

//  Multi-cycle controller that sequences one ARM data-processing instruction through

---
 rtl/dp_exec_ctrl_pkg.sv | 53 +++++
 rtl/dp_exec_ctrl_cond_check.sv | 45 ++++
 rtl/dp_exec_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dp_exec_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_exec_ctrl_pkg.sv
// Shared definitions for the data-processing execute controller:
// opcodes, condition codes, flag indices, FSM states.
package dp_exec_ctrl_pkg;

  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB,
    OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN,
    OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } opcode_e;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC,
    CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT,
    CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COND,
    S_RS_READ,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  // Compare/test opcodes have no destination write
  function automatic logic is_test(input logic [3:0] opc);
    return opc[3:2] == 2'b10;
  endfunction

  // Test ops reuse the ALU op that computes the same result
  function automatic logic [3:0] alu_op_of(input logic [3:0] opc);
    logic [3:0] op;
    unique case (opc)
      OP_TST:  op = OP_AND;
      OP_TEQ:  op = OP_EOR;
      OP_CMP:  op = OP_SUB;
      OP_CMN:  op = OP_ADD;
      default: op = opc;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dp_exec_ctrl_cond_check.sv
// ARM condition-code evaluator against an NZCV word.
// Purely combinational so the branch unit can reuse it.
module dp_exec_ctrl_cond_check
  import dp_exec_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = nzcv[FN];
  assign z = nzcv[FZ];
  assign c = nzcv[FC];
  assign v = nzcv[FV];

  // Decode condition field into pass/fail
  always_comb begin
    pass = 1'b0;
    unique case (cond_e'(cond))
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = n == v;
      CC_LT: pass = n != v;
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_exec_ctrl.sv
// Multi-cycle sequencer for one ARM data-processing instruction.
// Owns the NZCV register; all strobes and controls are registered.
module dp_exec_ctrl
  import dp_exec_ctrl_pkg::*;
#(
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  input  logic [3:0]         alu_nzcv,
  output logic [RADDR_W-1:0] rn_addr,
  output logic [RADDR_W-1:0] rm_addr,
  output logic [RADDR_W-1:0] rd_addr,
  output logic               rd_we,
  output logic               opa_we,
  output logic               opb_we,
  output logic               rs_we,
  output logic               imm_sel,
  output logic [1:0]         shift_type,
  output logic [7:0]         shift_amt,
  output logic               shift_by_rs,
  output logic [3:0]         alu_op,
  output logic               alu_c,
  output logic               alu_v,
  output logic [3:0]         flags,
  output logic               done
);

  state_e      state;
  state_e      next_state;
  logic [31:0] ir;
  logic [31:0] ir_n;
  logic        accept;
  logic [3:0]  cond_sel;
  logic        cond_pass;
  logic        pass_q;

  logic               ready_d;
  logic               rd_we_d;
  logic               opa_we_d;
  logic               opb_we_d;
  logic               rs_we_d;
  logic               done_d;
  logic [RADDR_W-1:0] rn_d;
  logic [RADDR_W-1:0] rm_d;
  logic [RADDR_W-1:0] rd_d;
  logic               imm_d;
  logic [1:0]         st_d;
  logic [7:0]         sa_d;
  logic               by_rs_d;
  logic [3:0]         op_d;

  logic unused_ok;
  assign unused_ok = ^ir[27:26];

  assign accept = (state == S_IDLE) && instr_valid;
  assign ir_n   = accept ? instr : ir;

  // In IDLE the incoming word is checked so a cond-fail can retire in COND
  assign cond_sel = (state == S_IDLE) ? instr[31:28] : ir[31:28];

  dp_exec_ctrl_cond_check u_cond (
    .cond (cond_sel),
    .nzcv (flags),
    .pass (cond_pass)
  );

  assign alu_c = flags[FC];
  assign alu_v = flags[FV];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state sequencing
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (instr_valid) next_state = S_COND;
      S_COND: begin
        if (!cond_pass)             next_state = S_WB;
        else if (!ir[25] && ir[4])  next_state = S_RS_READ;
        else                        next_state = S_READ;
      end
      S_RS_READ: next_state = S_READ;
      S_READ:    next_state = S_EXEC;
      S_EXEC:    next_state = S_WB;
      S_WB:      next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Output values for the coming cycle
  always_comb begin
    ready_d  = next_state == S_IDLE;
    rs_we_d  = next_state == S_RS_READ;
    opa_we_d = next_state == S_READ;
    opb_we_d = (next_state == S_READ) && !ir_n[25];
    rd_we_d  = (state == S_EXEC) && !is_test(ir_n[24:21]);
    done_d   = (state == S_EXEC) || (accept && !cond_pass);
    rn_d     = RADDR_W'(ir_n[19:16]);
    rd_d     = RADDR_W'(ir_n[15:12]);
    rm_d     = (next_state == S_RS_READ) ? RADDR_W'(ir_n[11:8])
                                         : RADDR_W'(ir_n[3:0]);
    imm_d    = ir_n[25];
    by_rs_d  = !ir_n[25] && ir_n[4];
    op_d     = alu_op_of(ir_n[24:21]);
    st_d     = ir_n[6:5];
    sa_d     = ir_n[4] ? 8'd0 : {3'b000, ir_n[11:7]};
    if (ir_n[25]) begin
      st_d = SH_ROR;
      sa_d = {3'b000, ir_n[11:8], 1'b0};
    end
  end

  // Registered controls and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ready <= 1'b1;
      rd_we       <= 1'b0;
      opa_we      <= 1'b0;
      opb_we      <= 1'b0;
      rs_we       <= 1'b0;
      done        <= 1'b0;
      rn_addr     <= '0;
      rm_addr     <= '0;
      rd_addr     <= '0;
      imm_sel     <= 1'b0;
      shift_type  <= 2'b00;
      shift_amt   <= 8'd0;
      shift_by_rs <= 1'b0;
      alu_op      <= 4'd0;
    end else begin
      instr_ready <= ready_d;
      rd_we       <= rd_we_d;
      opa_we      <= opa_we_d;
      opb_we      <= opb_we_d;
      rs_we       <= rs_we_d;
      done        <= done_d;
      rn_addr     <= rn_d;
      rm_addr     <= rm_d;
      rd_addr     <= rd_d;
      imm_sel     <= imm_d;
      shift_type  <= st_d;
      shift_amt   <= sa_d;
      shift_by_rs <= by_rs_d;
      alu_op      <= op_d;
    end
  end

  // Instruction capture, cond result and NZCV update at end of WB
  always_ff @(posedge clk) begin
    if (rst) begin
      ir     <= '0;
      pass_q <= 1'b0;
      flags  <= 4'b0000;
    end else begin
      ir <= ir_n;
      if (state == S_COND) pass_q <= cond_pass;
      if (state == S_WB && pass_q && (ir[20] || is_test(ir[24:21])))
        flags <= alu_nzcv;
    end
  end

endmodule

// File: tb/tb_dp_exec_ctrl.sv
// Randomised and directed bench for dp_exec_ctrl against a
// transaction-level model of latency, strobes, controls and NZCV.
module tb_dp_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [3:0]  alu_nzcv;
  logic [3:0]  rn_addr;
  logic [3:0]  rm_addr;
  logic [3:0]  rd_addr;
  logic        rd_we;
  logic        opa_we;
  logic        opb_we;
  logic        rs_we;
  logic        imm_sel;
  logic [1:0]  shift_type;
  logic [7:0]  shift_amt;
  logic        shift_by_rs;
  logic [3:0]  alu_op;
  logic        alu_c;
  logic        alu_v;
  logic [3:0]  flags;
  logic        done;

  always #5 clk = ~clk;

  dp_exec_ctrl #(.RADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_nzcv    (alu_nzcv),
    .rn_addr     (rn_addr),
    .rm_addr     (rm_addr),
    .rd_addr     (rd_addr),
    .rd_we       (rd_we),
    .opa_we      (opa_we),
    .opb_we      (opb_we),
    .rs_we       (rs_we),
    .imm_sel     (imm_sel),
    .shift_type  (shift_type),
    .shift_amt   (shift_amt),
    .shift_by_rs (shift_by_rs),
    .alu_op      (alu_op),
    .alu_c       (alu_c),
    .alu_v       (alu_v),
    .flags       (flags),
    .done        (done)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] mflags;
  logic [3:0] opmap [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                             4'h0, 4'h1, 4'h2, 4'h4, 4'hC, 4'hD, 4'hE, 4'hF};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_pass(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cc[0]) r = !r;
    return r;
  endfunction

  function automatic logic [3:0] add_nzcv(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic cin);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    return {s[31], s[31:0] == 32'd0, s[32],
            (a[31] == b[31]) && (s[31] != a[31])};
  endfunction

  function automatic logic [31:0] enc(input logic [3:0] cc, input logic i,
                                     input logic [3:0] op, input logic s,
                                     input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] op2);
    return {cc, 2'b00, i, op, s, rn, rd, op2};
  endfunction

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mflags = 4'b0000;
  endtask

  task automatic run(input string nm, input logic [31:0] ins,
                     input logic [3:0] nz, input bit noise, input bit abort);
    bit pass, isr, tst;
    int lat, w;
    int done_k, done_n, rdwe_n, opa_n, opb_n, rs_n, rs_k, opb_k;
    logic [3:0] rd_at, op_at, rn_at, rmb_at, rms_at;
    logic [7:0] sa_at;
    logic [1:0] st_at;
    logic imm_at, byrs_at, rdwe_at, c_exec, c_wb, v_wb;
    done_k = 0; done_n = 0; rdwe_n = 0; opa_n = 0; opb_n = 0;
    rs_n = 0; rs_k = 0; opb_k = 0;
    {rd_at, op_at, rn_at, rmb_at, rms_at} = '0;
    {sa_at, st_at, imm_at, byrs_at, rdwe_at, c_exec, c_wb, v_wb} = '0;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({nm, "/ready_in"}, 32'(instr_ready), 32'd1);
    pass = m_pass(ins[31:28], mflags);
    isr  = !ins[25] && ins[4];
    tst  = ins[24:21] >= 4'd8 && ins[24:21] <= 4'd11;
    lat  = !pass ? 1 : (isr ? 5 : 4);
    instr = ins;
    alu_nzcv = nz;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = $urandom;
    for (int k = 1; k <= 8; k++) begin
      if (abort && k == 4) begin
        chk({nm, "/abort_ready"}, 32'(instr_ready), 32'd1);
        chk({nm, "/abort_flags"}, 32'(flags), 32'd0);
        chk({nm, "/abort_rdwe"}, 32'(rd_we), 32'd0);
        chk({nm, "/abort_done"}, 32'(done), 32'd0);
        rst = 1'b0;
        mflags = 4'b0000;
        return;
      end
      if (done) begin
        done_n++; done_k = k;
        rd_at = rd_addr; op_at = alu_op; sa_at = shift_amt;
        st_at = shift_type; imm_at = imm_sel; byrs_at = shift_by_rs;
        rdwe_at = rd_we; c_wb = alu_c; v_wb = alu_v;
      end
      if (k == lat - 1) c_exec = alu_c;
      if (rd_we) rdwe_n++;
      if (opa_we) begin opa_n++; rn_at = rn_addr; end
      if (opb_we) begin opb_n++; opb_k = k; rmb_at = rm_addr; end
      if (rs_we) begin rs_n++; rs_k = k; rms_at = rm_addr; end
      if (noise && k == 2) begin instr_valid = 1'b1; instr = $urandom; end
      if (k == 3) instr_valid = 1'b0;
      if (abort && k == 3) rst = 1'b1;
      @(posedge clk); #1;
    end
    chk({nm, "/latency"}, 32'(done_k), 32'(lat));
    chk({nm, "/done_cnt"}, 32'(done_n), 32'd1);
    chk({nm, "/rd_we_cnt"}, 32'(rdwe_n), 32'(pass && !tst));
    chk({nm, "/opa_cnt"}, 32'(opa_n), 32'(pass));
    chk({nm, "/opb_cnt"}, 32'(opb_n), 32'(pass && !ins[25]));
    chk({nm, "/rs_cnt"}, 32'(rs_n), 32'(pass && isr));
    if (pass) begin
      chk({nm, "/rd_we_wb"}, 32'(rdwe_at), 32'(!tst));
      chk({nm, "/rd_addr"}, 32'(rd_at), 32'(ins[15:12]));
      chk({nm, "/rn_addr"}, 32'(rn_at), 32'(ins[19:16]));
      chk({nm, "/alu_op"}, 32'(op_at), 32'(opmap[ins[24:21]]));
      chk({nm, "/imm_sel"}, 32'(imm_at), 32'(ins[25]));
      chk({nm, "/shift_by_rs"}, 32'(byrs_at), 32'(isr));
      chk({nm, "/shift_type"}, 32'(st_at),
          32'(ins[25] ? 2'b11 : ins[6:5]));
      chk({nm, "/shift_amt"}, 32'(sa_at),
          ins[25] ? 32'(ins[11:8]) * 2 : (isr ? 32'd0 : 32'(ins[11:7])));
      chk({nm, "/alu_c_exec"}, 32'(c_exec), 32'(mflags[1]));
      chk({nm, "/alu_c_wb"}, 32'(c_wb), 32'(mflags[1]));
      chk({nm, "/alu_v_wb"}, 32'(v_wb), 32'(mflags[0]));
      if (!ins[25]) chk({nm, "/rm_addr"}, 32'(rmb_at), 32'(ins[3:0]));
      if (isr) begin
        chk({nm, "/rs_addr"}, 32'(rms_at), 32'(ins[11:8]));
        chk({nm, "/rs_then_opb"}, 32'(opb_k), 32'(rs_k + 1));
      end
      if (ins[20] || tst) mflags = nz;
    end
    chk({nm, "/flags"}, 32'(flags), 32'(mflags));
    chk({nm, "/ready_out"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] x;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    alu_nzcv = '0;
    mflags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/ready", 32'(instr_ready), 32'd1);
    chk("rst/flags", 32'(flags), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/rd_we", 32'(rd_we), 32'd0);
    chk("rst/strobes", 32'({opa_we, opb_we, rs_we}), 32'd0);
    chk("rst/addrs", 32'({rn_addr, rm_addr, rd_addr}), 32'd0);
    chk("rst/ctl", 32'({alu_op, shift_amt, shift_type, imm_sel, shift_by_rs}),
        32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("addeq_fail", enc(4'h0, 1'b1, 4'h4, 1'b0, 4'd1, 4'd2, 12'h005),
        4'b1111, 1'b0, 1'b0);
    chk("addeq_fail/flags0", 32'(flags), 32'd0);

    x = $urandom;
    run("cmp", enc(4'hE, 1'b0, 4'hA, 1'b1, 4'd3, 4'd0, 12'h003),
        add_nzcv(x, ~x, 1'b1), 1'b0, 1'b0);
    chk("cmp/flags_zc", 32'(flags), 32'b0110);

    pulse_rst();
    run("adds", enc(4'hE, 1'b1, 4'h4, 1'b1, 4'd2, 4'd1, 12'h001),
        add_nzcv(32'hFFFF_FFFF, 32'd1, 1'b0), 1'b0, 1'b0);
    chk("adds/flags", 32'(flags), 32'b0110);

    run("adc_nos", enc(4'hE, 1'b0, 4'h5, 1'b0, 4'd4, 4'd5, 12'h006),
        4'b1001, 1'b0, 1'b0);
    chk("adc_nos/flags", 32'(flags), 32'b0110);

    run("mov_lsl_rs", enc(4'hE, 1'b0, 4'hD, 1'b0, 4'd0, 4'd0, 12'h211),
        4'b0000, 1'b0, 1'b0);

    run("abort", enc(4'hE, 1'b1, 4'h4, 1'b1, 4'd1, 4'd1, 12'h0FF),
        4'b1111, 1'b0, 1'b1);
    run("after_abort", enc(4'hE, 1'b1, 4'h2, 1'b1, 4'd6, 4'd7, 12'h4A3),
        4'b1000, 1'b0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      ins = $urandom;
      ins[27:26] = 2'b00;
      if (!ins[25] && ins[4]) ins[7] = 1'b0;
      run($sformatf("rnd%0d", t), ins, 4'($urandom), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
